vinstru_seq: RTL and testbench

Acquisition scheduler for the virtual instrument. It runs a software-configured sequence of N captures into successive BRAM pages, driving the instrument's run and reset levels and handshaking on its done level. Sits in the axi_aclk domain between the register file (config/status registers) and the vinstru core; it replaces direct software control of the run and reset bits.

---
 rtl/vinstru_seq.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vinstru_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vinstru_seq.sv
// Acquisition scheduler: runs N captures into successive BRAM pages, sequencing vinstru reset/run/done.
// Optional build macro VINSTRU_SEQ_TIMEOUT_EN adds a per-capture done timeout (err_timeout).
module vinstru_seq #(
  parameter int RST_CYCLES = 4,
  parameter int PAGE_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [15:0]          num_acq,
  input  logic [31:0]          gap_cycles,
  input  logic [31:0]          timeout_cycles,
  output logic                 vinstru_run,
  output logic                 vinstru_reset,
  input  logic                 vinstru_done,
  output logic [PAGE_BITS-1:0] page_idx,
  output logic [15:0]          acq_count,
  output logic                 busy,
  output logic                 seq_done,
  output logic                 aborted,
  output logic                 err_timeout
);

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CLEAR     = 3'd1,
    ARM       = 3'd2,
    WAIT_DONE = 3'd3,
    RELEASE   = 3'd4,
    GAP       = 3'd5,
    FINISH    = 3'd6,
    ABORT     = 3'd7
  } state_t;

  state_t               state_q, state_d;
  logic                 run_q, run_d;
  logic                 vrst_q, vrst_d;
  logic [PAGE_BITS-1:0] page_q, page_d;
  logic [15:0]          count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 seq_done_q, seq_done_d;
  logic                 aborted_q, aborted_d;
  logic [15:0]          num_q, num_d;
  logic [31:0]          gap_q, gap_d;
  logic [31:0]          gap_cnt_q, gap_cnt_d;
  logic [RCW-1:0]       rst_cnt_q, rst_cnt_d;
  logic [15:0]          count_inc_s;
  logic                 abortable_s;
  logic                 take_timeout_s;

  assign count_inc_s = count_q + 16'd1;
  // FINISH and ABORT are already on their way to IDLE, so a late abort changes nothing there
  assign abortable_s = (state_q == CLEAR) || (state_q == ARM) || (state_q == WAIT_DONE) ||
                       (state_q == RELEASE) || (state_q == GAP);

`ifdef VINSTRU_SEQ_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;

  // Done-wait watchdog: counts WAIT_DONE cycles and flags expiry unless abort or done wins
  always_comb begin
    tmo_d          = tmo_q;
    tmo_cnt_d      = tmo_cnt_q;
    err_d          = err_q;
    take_timeout_s = 1'b0;
    if ((state_q == IDLE) && start) begin
      tmo_d = timeout_cycles;
      err_d = 1'b0;
    end else if (state_q == ARM) begin
      tmo_cnt_d = 32'd0;
    end else if (state_q == WAIT_DONE) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
      if (!abort && !vinstru_done && (tmo_q != 32'd0) && (tmo_cnt_q == tmo_q - 32'd1)) begin
        take_timeout_s = 1'b1;
        err_d          = 1'b1;
      end else begin
        take_timeout_s = 1'b0;
      end
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  assign err_timeout = err_q;
`else
  logic unused_tmo_s;
  assign unused_tmo_s   = ^timeout_cycles;
  assign take_timeout_s = 1'b0;
  assign err_timeout    = 1'b0;
`endif

  // Sequencer next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    run_d      = run_q;
    vrst_d     = vrst_q;
    page_d     = page_q;
    count_d    = count_q;
    busy_d     = busy_q;
    seq_done_d = 1'b0;
    aborted_d  = aborted_q;
    num_d      = num_q;
    gap_d      = gap_q;
    gap_cnt_d  = gap_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    if ((abort && abortable_s) || take_timeout_s) begin
      state_d   = ABORT;
      run_d     = 1'b0;
      vrst_d    = 1'b1;
      rst_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            num_d     = num_acq;
            gap_d     = gap_cycles;
            count_d   = 16'd0;
            page_d    = '0;
            aborted_d = 1'b0;
            if (num_acq == 16'd0) begin
              state_d    = FINISH;
              seq_done_d = 1'b1;
            end else begin
              state_d   = CLEAR;
              busy_d    = 1'b1;
              vrst_d    = 1'b1;
              rst_cnt_d = '0;
            end
          end else begin
            state_d = IDLE;
          end
        end
        CLEAR: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d = ARM;
            vrst_d  = 1'b0;
          end else begin
            rst_cnt_d = rst_cnt_q + RCW'(1'b1);
          end
        end
        ARM: begin
          if (!vinstru_done) begin
            state_d = WAIT_DONE;
            run_d   = 1'b1;
          end else begin
            run_d = 1'b0;
          end
        end
        WAIT_DONE: begin
          if (vinstru_done) begin
            state_d = RELEASE;
            run_d   = 1'b0;
          end else begin
            run_d = 1'b1;
          end
        end
        RELEASE: begin
          if (!vinstru_done) begin
            count_d = count_inc_s;
            if (count_inc_s == num_q) begin
              state_d    = FINISH;
              busy_d     = 1'b0;
              seq_done_d = 1'b1;
            end else begin
              state_d   = GAP;
              page_d    = page_q + PAGE_BITS'(1'b1);
              gap_cnt_d = 32'd0;
            end
          end else begin
            state_d = RELEASE;
          end
        end
        GAP: begin
          // A zero gap still spends one cycle here
          if ((gap_q == 32'd0) || (gap_cnt_q == gap_q - 32'd1)) begin
            state_d   = CLEAR;
            vrst_d    = 1'b1;
            rst_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 32'd1;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        ABORT: begin
          if (rst_cnt_q == RST_LAST) begin
            state_d   = IDLE;
            vrst_d    = 1'b0;
            busy_d    = 1'b0;
            aborted_d = 1'b1;
          end else begin
            rst_cnt_d = rst_cnt_q + RCW'(1'b1);
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = 1'b0;
          vrst_d  = 1'b0;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      vrst_q     <= 1'b0;
      page_q     <= '0;
      count_q    <= 16'd0;
      busy_q     <= 1'b0;
      seq_done_q <= 1'b0;
      aborted_q  <= 1'b0;
      num_q      <= 16'd0;
      gap_q      <= 32'd0;
      gap_cnt_q  <= 32'd0;
      rst_cnt_q  <= '0;
`ifdef VINSTRU_SEQ_TIMEOUT_EN
      tmo_q      <= 32'd0;
      tmo_cnt_q  <= 32'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      run_q      <= run_d;
      vrst_q     <= vrst_d;
      page_q     <= page_d;
      count_q    <= count_d;
      busy_q     <= busy_d;
      seq_done_q <= seq_done_d;
      aborted_q  <= aborted_d;
      num_q      <= num_d;
      gap_q      <= gap_d;
      gap_cnt_q  <= gap_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
`ifdef VINSTRU_SEQ_TIMEOUT_EN
      tmo_q      <= tmo_d;
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign vinstru_run   = run_q;
  assign vinstru_reset = vrst_q;
  assign page_idx      = page_q;
  assign acq_count     = count_q;
  assign busy          = busy_q;
  assign seq_done      = seq_done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_vinstru_seq.sv
// Directed bench for vinstru_seq with a simple vinstru done model and protocol monitors.
module tb_vinstru_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] num_acq;
  logic [31:0] gap_cycles;
  logic [31:0] timeout_cycles;
  logic        vinstru_run;
  logic        vinstru_reset;
  logic        vinstru_done;
  logic [1:0]  page_idx;
  logic [15:0] acq_count;
  logic        busy;
  logic        seq_done;
  logic        aborted;
  logic        err_timeout;

  logic        model_en;
  logic        model_done;
  logic        force_done;
  int          hi_cnt;
  int          drop_cnt;

  int checks;
  int errors;

  int run_rises;
  int rst_pulses;
  int rst_bad;
  int rst_run;
  int done_pulses;
  int busy_at_done;
  int pages[$];
  logic run_prev;

  vinstru_seq #(.RST_CYCLES(4), .PAGE_BITS(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .num_acq(num_acq), .gap_cycles(gap_cycles), .timeout_cycles(timeout_cycles),
    .vinstru_run(vinstru_run), .vinstru_reset(vinstru_reset), .vinstru_done(vinstru_done),
    .page_idx(page_idx), .acq_count(acq_count), .busy(busy), .seq_done(seq_done),
    .aborted(aborted), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign vinstru_done = model_en ? model_done : force_done;

  // Instrument model: done rises 50 cycles into run, falls 2 cycles after run drops
  always @(posedge clk) begin
    if (reset) begin
      model_done <= 1'b0;
      hi_cnt     <= 0;
      drop_cnt   <= 0;
    end else if (vinstru_run) begin
      drop_cnt <= 0;
      if (hi_cnt == 49) model_done <= 1'b1;
      else hi_cnt <= hi_cnt + 1;
    end else begin
      hi_cnt <= 0;
      if (model_done) begin
        if (drop_cnt == 1) model_done <= 1'b0;
        else drop_cnt <= drop_cnt + 1;
      end
    end
  end

  // Monitors sampled on the falling edge
  initial begin
    run_rises = 0; rst_pulses = 0; rst_bad = 0; rst_run = 0;
    done_pulses = 0; busy_at_done = 0; run_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (vinstru_run && !run_prev) begin
        run_rises++;
        pages.push_back(int'(page_idx));
      end
      run_prev = vinstru_run;
      if (vinstru_reset) begin
        rst_run++;
      end else if (rst_run != 0) begin
        rst_pulses++;
        if (rst_run != 4) rst_bad++;
        rst_run = 0;
      end
      if (seq_done) begin
        done_pulses++;
        if (busy) busy_at_done++;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start(input logic [15:0] n, input logic [31:0] g, input logic [31:0] t);
    @(negedge clk);
    num_acq = n; gap_cycles = g; timeout_cycles = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n;
    n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_rises(input string tag, input int target, input int limit);
    int n;
    n = 0;
    while (run_rises < target && n < limit) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, run_rises, target);
  endtask

  int base_runs, base_rst, base_done, base_pg;

  task automatic snap();
    base_runs = run_rises;
    base_rst  = rst_pulses;
    base_done = done_pulses;
    base_pg   = pages.size();
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    num_acq = 16'd0; gap_cycles = 32'd0; timeout_cycles = 32'd0;
    model_en = 1'b1; force_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_run", {31'd0, vinstru_run}, 32'd0);
    check_val("rst_vreset", {31'd0, vinstru_reset}, 32'd0);
    check_val("rst_page", {30'd0, page_idx}, 32'd0);
    check_val("rst_count", {16'd0, acq_count}, 32'd0);
    check_val("rst_flags", {28'd0, busy, seq_done, aborted, err_timeout}, 32'd0);
    reset = 1'b0;

    // Normal three-capture run
    snap();
    pulse_start(16'd3, 32'd10, 32'd0);
    check_val("norm_busy_n1", {31'd0, busy}, 32'd1);
    check_val("norm_vrst_n1", {31'd0, vinstru_reset}, 32'd1);
    wait_idle("norm_idle", 2000);
    repeat (3) @(negedge clk);
    check_val("norm_runs", run_rises - base_runs, 32'd3);
    for (int i = 0; i < 3; i++) check_val("norm_page", pages[base_pg + i], i);
    check_val("norm_rst_pulses", rst_pulses - base_rst, 32'd3);
    check_val("norm_rst_len", rst_bad, 32'd0);
    check_val("norm_seq_done", done_pulses - base_done, 32'd1);
    check_val("norm_busy_at_done", busy_at_done, 32'd0);
    check_val("norm_count", {16'd0, acq_count}, 32'd3);
    check_val("norm_page_hold", {30'd0, page_idx}, 32'd2);

    // Zero captures
    snap();
    pulse_start(16'd0, 32'd5, 32'd0);
    check_val("zero_done", {30'd0, seq_done, busy}, 32'd2);
    @(negedge clk);
    check_val("zero_done_off", {31'd0, seq_done}, 32'd0);
    repeat (5) @(negedge clk);
    check_val("zero_count", {16'd0, acq_count}, 32'd0);
    check_val("zero_activity", (run_rises - base_runs) + (rst_pulses - base_rst) + rst_run, 32'd0);

    // Start during an active sequence is ignored
    snap();
    pulse_start(16'd2, 32'd5, 32'd0);
    repeat (20) @(negedge clk);
    pulse_start(16'd7, 32'd5, 32'd0);
    wait_idle("ign_idle", 2000);
    check_val("ign_count", {16'd0, acq_count}, 32'd2);
    check_val("ign_runs", run_rises - base_runs, 32'd2);
    check_val("ign_seq_done", done_pulses - base_done, 32'd1);

    // Page wrap over six captures
    snap();
    pulse_start(16'd6, 32'd0, 32'd0);
    wait_idle("wrap_idle", 4000);
    for (int i = 0; i < 6; i++) check_val("wrap_page", pages[base_pg + i], i % 4);
    check_val("wrap_count", {16'd0, acq_count}, 32'd6);
    check_val("wrap_page_hold", {30'd0, page_idx}, 32'd1);

    // Abort while waiting for done on capture 2
    snap();
    pulse_start(16'd3, 32'd3, 32'd0);
    wait_rises("abort_reach2", base_runs + 2, 1000);
    repeat (10) @(negedge clk);
    check_val("abort_pre_run", {31'd0, vinstru_run}, 32'd1);
    pulse_abort();
    check_val("abort_run_drop", {31'd0, vinstru_run}, 32'd0);
    check_val("abort_vrst", {31'd0, vinstru_reset}, 32'd1);
    wait_idle("abort_idle", 100);
    @(negedge clk);
    check_val("abort_rst_pulses", rst_pulses - base_rst, 32'd3);
    check_val("abort_rst_len", rst_bad, 32'd0);
    check_val("abort_flag", {31'd0, aborted}, 32'd1);
    check_val("abort_count", {16'd0, acq_count}, 32'd1);
    check_val("abort_no_done", done_pulses - base_done, 32'd0);
    pulse_start(16'd0, 32'd0, 32'd0);
    check_val("abort_cleared", {31'd0, aborted}, 32'd0);

    // Stale done held across CLEAR exit
    model_en = 1'b0; force_done = 1'b1;
    pulse_start(16'd1, 32'd0, 32'd0);
    repeat (20) @(negedge clk);
    check_val("stale_run_low", {30'd0, vinstru_run, busy}, 32'd1);
    force_done = 1'b0;
    @(negedge clk);
    check_val("stale_run_rise", {31'd0, vinstru_run}, 32'd1);
    force_done = 1'b1;
    repeat (2) @(negedge clk);
    force_done = 1'b0;
    wait_idle("stale_idle", 100);
    check_val("stale_count", {16'd0, acq_count}, 32'd1);

    // Done never arrives
`ifdef VINSTRU_SEQ_TIMEOUT_EN
    pulse_start(16'd1, 32'd0, 32'd100);
    repeat (100) @(negedge clk);
    check_val("tmo_not_yet", {31'd0, err_timeout}, 32'd0);
    begin
      int n;
      n = 0;
      while (!err_timeout && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    check_val("tmo_err", {31'd0, err_timeout}, 32'd1);
    wait_idle("tmo_idle", 100);
    check_val("tmo_aborted", {31'd0, aborted}, 32'd1);
`else
    pulse_start(16'd1, 32'd0, 32'd100);
    repeat (300) @(negedge clk);
    check_val("notmo_wait", {30'd0, vinstru_run, err_timeout}, 32'd2);
    pulse_abort();
    wait_idle("notmo_idle", 100);
`endif
    pulse_start(16'd1, 32'd0, 32'd0);
    repeat (10050) @(negedge clk);
    check_val("nolimit_wait", {29'd0, vinstru_run, busy, err_timeout}, 32'd6);
    pulse_abort();
    wait_idle("nolimit_idle", 100);

    // Synchronous reset mid-sequence
    model_en = 1'b1;
    pulse_start(16'd3, 32'd0, 32'd0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("srst_outputs", {vinstru_run, vinstru_reset, page_idx, acq_count,
                               busy, seq_done, aborted, err_timeout}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("srst_stays_idle", {30'd0, busy, vinstru_reset}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
